// File: rtl/uart_pkg.sv
// Shared serial-link definitions: frame states, line levels and sample-counter sizing.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uartState_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int DEFAULT_OVERSAMPLE = 16;

  function automatic int sampleWidth(input int oversample);
    return (oversample <= 2) ? 1 : $clog2(oversample);
  endfunction

  localparam int SAMPLE_W = sampleWidth(DEFAULT_OVERSAMPLE);

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial output of the transmitter.
// Master is the CPU-side driver, slave is uart_tx.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 load;
  logic [DATA_BITS-1:0] din;
  logic                 tx;
  logic                 ready;
  logic                 done;
  logic [3:0]           bitIndex;

  modport master (
    output load, din,
    input  tx, ready, done, bitIndex
  );

  modport slave (
    input  load, din,
    output tx, ready, done, bitIndex
  );
endinterface

// File: rtl/uart_tx_bitcnt.sv
// Per-bit sample counter, the transmit-side twin of the receiver's bit-sampling counter.
// Counts 0..OVERSAMPLE-1 while enabled; wrap marks the last sample of a serial bit.
module uart_tx_bitcnt import uart_pkg::*; #(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int W          = sampleWidth(OVERSAMPLE)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic wrap
);

  logic [W-1:0] count;

  assign wrap = en && (count == W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Oversampled serial transmitter: start(0), data LSB-first, optional even parity, stop(1).
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_tx import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  uartState_e           state, nextState;
  logic [DATA_BITS-1:0] shiftReg, nextShift;
  logic [3:0]           bitIndex, nextBitIndex;
  logic                 txReg, txNext;
  logic                 wrap;
`ifdef UART_TX_PARITY_EN
  logic                 parityBit;
`endif

  uart_tx_bitcnt #(
    .OVERSAMPLE(OVERSAMPLE)
  ) bitCnt (
    .clk   (clk),
    .rst   (rst),
    .en    (state != IDLE),
    .clear (state == IDLE),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitIndex <= '0;
      txReg    <= IDLE_LEVEL;
    end else begin
      state    <= nextState;
      shiftReg <= nextShift;
      bitIndex <= nextBitIndex;
      txReg    <= txNext;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte as accepted, since the shift register is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parityBit <= 1'b0;
    end else if (state == IDLE && bus.load) begin
      parityBit <= ^bus.din;
    end
  end
`endif

  always_comb begin
    nextState    = state;
    nextShift    = shiftReg;
    nextBitIndex = bitIndex;
    case (state)
      IDLE: begin
        if (bus.load) begin
          nextState = START;
          nextShift = bus.din;
        end
      end
      START: begin
        if (wrap) begin
          nextState    = DATA;
          nextBitIndex = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          nextShift = shiftReg >> 1;
          if (bitIndex == LAST_BIT) begin
            nextBitIndex = '0;
`ifdef UART_TX_PARITY_EN
            nextState    = PARITY;
`else
            nextState    = STOP;
`endif
          end else begin
            nextBitIndex = bitIndex + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (wrap) begin
          nextState = STOP;
        end
      end
`endif
      STOP: begin
        if (wrap) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState    = IDLE;
        nextShift    = '0;
        nextBitIndex = '0;
      end
    endcase
  end

  // tx is registered from the upcoming state so the line changes right at each bit edge.
  always_comb begin
    txNext = IDLE_LEVEL;
    case (nextState)
      START:   txNext = START_LEVEL;
      DATA:    txNext = nextShift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txNext = parityBit;
`endif
      default: txNext = IDLE_LEVEL;
    endcase
  end

  assign bus.tx       = txReg;
  assign bus.ready    = (state == IDLE);
  assign bus.done     = (state == STOP) && wrap;
  assign bus.bitIndex = bitIndex;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: randomized frames compared cycle by cycle with a frame model.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

  localparam int DB = 8;
  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = (DB + 2 + PAR) * OS;
  localparam logic [6:0] IDLE_VEC = 7'b1100000;

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  uart_tx_if #(.DATA_BITS(DB)) bus ();

  uart_tx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] obsVec;
  assign obsVec = {bus.tx, bus.ready, bus.done, bus.bitIndex};

  // Expected {tx, ready, done, bitIndex} in cycle c after the accepting edge.
  function automatic logic [6:0] expFrame(input logic [DB-1:0] data, input int c);
    int         bitNo;
    logic       txE;
    logic [3:0] idxE;
    bitNo = c / OS;
    txE   = 1'b1;
    idxE  = 4'd0;
    if (bitNo == 0) begin
      txE = 1'b0;
    end else if (bitNo <= DB) begin
      txE  = data[bitNo-1];
      idxE = 4'(bitNo - 1);
    end else if (PAR == 1 && bitNo == DB + 1) begin
      txE = ^data;
    end
    return {txE, 1'b0, (c == FL - 1), idxE};
  endfunction

  task automatic checkIdle(input string name);
    checks++;
    if (obsVec !== IDLE_VEC)
      $display("[TB] FAIL %s: got tx/ready/done/idx=%b expected %b", name, obsVec, IDLE_VEC);
    else
      passes++;
  endtask

  // Called at the negedge before the accepting edge; returns at cycle 0 of the frame.
  task automatic applyStimulus(input logic [DB-1:0] data, input bit keepLoad);
    bus.load = 1'b1;
    bus.din  = data;
    @(negedge clk);
    if (!keepLoad) bus.load = 1'b0;
  endtask

  // Checks cycles 0..FL-1 of a frame and the idle cycle after it.
  task automatic checkFrame(input logic [DB-1:0] data, input bit disturb, input string name);
    logic [6:0] exp;
    for (int c = 0; c < FL; c++) begin
      exp = expFrame(data, c);
      checks++;
      if (obsVec !== exp)
        $display("[TB] FAIL %s cycle %0d: got tx/ready/done/idx=%b expected %b", name, c, obsVec, exp);
      else
        passes++;
      if (disturb) begin
        bus.din  = (c == 40) ? DB'(8'h3C) : DB'($urandom);
        bus.load = (c == 40);
      end
      @(negedge clk);
    end
    checkIdle({name, " end-idle"});
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.din  = '0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkIdle("idle-hold");
    end
  endtask

  task automatic test_frame_a5();
    applyStimulus(8'hA5, 1'b0);
    checkFrame(8'hA5, 1'b0, "frame-A5");
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = DB'($urandom);
      applyStimulus(d, 1'b0);
      checkFrame(d, 1'b0, "frame-rand");
      repeat ($urandom_range(3, 0)) begin
        @(negedge clk);
        checkIdle("gap-rand");
      end
    end
  endtask

  task automatic test_ignored_load();
    logic [DB-1:0] d;
    d = DB'($urandom);
    applyStimulus(d, 1'b0);
    checkFrame(d, 1'b1, "busy-load");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkIdle("no-second-frame");
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(8'h00, 1'b1);
    checkFrame(8'h00, 1'b0, "b2b-first");
    bus.din = 8'hFF;
    @(negedge clk);
    bus.load = 1'b0;
    checkFrame(8'hFF, 1'b0, "b2b-second");
  endtask

  task automatic test_reset_midframe();
    logic [DB-1:0] d;
    logic [6:0]    exp;
    d = DB'($urandom);
    applyStimulus(d, 1'b0);
    for (int c = 0; c <= 70; c++) begin
      exp = expFrame(d, c);
      checks++;
      if (obsVec !== exp)
        $display("[TB] FAIL pre-reset cycle %0d: got %b expected %b", c, obsVec, exp);
      else
        passes++;
      if (c < 70) @(negedge clk);
    end
    rst      = 1'b1;
    bus.load = 1'b1;
    bus.din  = DB'($urandom);
    #1;
    checkIdle("async-reset");
    @(negedge clk);
    checkIdle("reset-beats-load");
    rst      = 1'b0;
    bus.load = 1'b0;
    @(negedge clk);
    checkIdle("post-reset");
    d = DB'($urandom);
    applyStimulus(d, 1'b0);
    checkFrame(d, 1'b0, "post-reset-frame");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    applyStimulus(8'h07, 1'b0);
    checkFrame(8'h07, 1'b0, "parity-07");
  endtask
`endif

  initial begin
    checks = 0;
    passes = 0;
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.din  = '0;
    test_reset();
    test_frame_a5();
    test_random();
    test_ignored_load();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
